// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared constants and FSM encoding for the 4-lane receive demux
package phy_rx_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LANES  = 4;
   localparam int LANE_IDX_W = $clog2(DEF_LANES);
   typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
endpackage

// File: rtl/phy_rx_lane_demux_if.sv
// phy_rx_lane_demux_if: link-side byte stream and lane-side output group; grp_cnt under PHY_RX_GRP_CNT_EN
interface phy_rx_lane_demux_if import phy_rx_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              out_ready;
   logic [DATA_W-1:0] Out0, Out1, Out2, Out3;
   logic              valid_out0, valid_out1, valid_out2, valid_out3;
   logic              out_valid;
   logic              ovf;
`ifdef PHY_RX_GRP_CNT_EN
   logic [15:0]       grp_cnt;
`endif
   modport master (
      output data_in, valid_in, out_ready,
      input  Out0, Out1, Out2, Out3, valid_out0, valid_out1, valid_out2, valid_out3, out_valid, ovf
`ifdef PHY_RX_GRP_CNT_EN
      , input grp_cnt
`endif
   );
   modport slave (
      input  data_in, valid_in, out_ready,
      output Out0, Out1, Out2, Out3, valid_out0, valid_out1, valid_out2, valid_out3, out_valid, ovf
`ifdef PHY_RX_GRP_CNT_EN
      , output grp_cnt
`endif
   );
endinterface

// File: rtl/phy_rx_out_slot.sv
// phy_rx_out_slot: output holding register with valid/ready accept and sticky overflow; grp_cnt under PHY_RX_GRP_CNT_EN
module phy_rx_out_slot import phy_rx_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LANES  = DEF_LANES
) (
   input  logic                          clk,
   input  logic                          reset_L,
   input  logic                          load,
   input  logic [LANES-1:0][DATA_W-1:0]  ld_data,
   input  logic [LANES-1:0]              ld_vld,
   input  logic                          out_ready,
   output logic [LANES-1:0][DATA_W-1:0]  data_q,
   output logic [LANES-1:0]              vld_q,
   output logic                          out_valid_q,
   output logic                          ovf_q
`ifdef PHY_RX_GRP_CNT_EN
   , output logic [15:0]                 grp_cnt_q
`endif
);
   logic [LANES-1:0][DATA_W-1:0] data_d;
   logic [LANES-1:0]             vld_d;
   logic                         out_valid_d, ovf_d, can_load, take;
   always_comb begin
      can_load    = !out_valid_q || out_ready;
      take        = load && can_load;
      data_d      = take ? ld_data : data_q;
      vld_d       = take ? ld_vld : (out_valid_q && out_ready) ? '0 : vld_q;
      out_valid_d = take ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
      ovf_d       = ovf_q || (load && !can_load);
   end
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_q      <= '0;
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         data_q      <= data_d;
         vld_q       <= vld_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end
`ifdef PHY_RX_GRP_CNT_EN
   logic [15:0] grp_cnt_d;
   always_comb grp_cnt_d = grp_cnt_q + {15'd0, take};
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) grp_cnt_q <= '0;
      else          grp_cnt_q <= grp_cnt_d;
   end
`endif
endmodule

// File: rtl/phy_rx_lane_demux.sv
// phy_rx_lane_demux: un-stripes a byte stream into 4-lane groups with gap flush; PHY_RX_GRP_CNT_EN adds grp_cnt
module phy_rx_lane_demux import phy_rx_pkg::*; #(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LANES     = DEF_LANES,
   parameter int FLUSH_CYC = 3
) (
   input logic               clk,
   input logic               reset_L,
   phy_rx_lane_demux_if.slave bus
);
   state_t                       state_q, state_d;
   logic [LANE_IDX_W-1:0]        lane_idx_q, lane_idx_d;
   logic [3:0]                   gap_cnt_q, gap_cnt_d;
   logic [LANES-1:0][DATA_W-1:0] cap_q, cap_d, ld_data, out_data;
   logic [LANES-1:0]             cap_vld_q, cap_vld_d, ld_vld, out_vld;
   logic                         load;
   always_comb begin
      state_d    = state_q;
      lane_idx_d = lane_idx_q;
      gap_cnt_d  = gap_cnt_q;
      cap_d      = cap_q;
      cap_vld_d  = cap_vld_q;
      load       = 1'b0;
      ld_data    = '0;
      ld_vld     = '0;
      if (state_q == IDLE) begin
         if (bus.valid_in) begin
            cap_d[0]     = bus.data_in;
            cap_vld_d[0] = 1'b1;
            lane_idx_d   = LANE_IDX_W'(1);
            state_d      = COLLECT;
         end
      end else if (bus.valid_in) begin
         cap_d[lane_idx_q]     = bus.data_in;
         cap_vld_d[lane_idx_q] = 1'b1;
         gap_cnt_d             = '0;
         lane_idx_d            = lane_idx_q + LANE_IDX_W'(1);
         load                  = lane_idx_q == LANE_IDX_W'(LANES - 1);
         ld_data               = cap_d;
         ld_vld                = cap_vld_d;
      end else if (gap_cnt_q == 4'(FLUSH_CYC - 1)) begin
         load    = 1'b1;
         ld_data = cap_q;
         ld_vld  = cap_vld_q;
      end else begin
         gap_cnt_d = gap_cnt_q + 4'd1;
      end
      // Any load (taken or dropped) ends the group; unfilled lanes read back as zero
      if (load) begin
         state_d    = IDLE;
         lane_idx_d = '0;
         gap_cnt_d  = '0;
         cap_d      = '0;
         cap_vld_d  = '0;
      end
   end
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         lane_idx_q <= '0;
         gap_cnt_q  <= '0;
         cap_q      <= '0;
         cap_vld_q  <= '0;
      end else begin
         state_q    <= state_d;
         lane_idx_q <= lane_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         cap_q      <= cap_d;
         cap_vld_q  <= cap_vld_d;
      end
   end
   phy_rx_out_slot #(.DATA_W(DATA_W), .LANES(LANES)) u_slot (
      .clk         (clk),
      .reset_L     (reset_L),
      .load        (load),
      .ld_data     (ld_data),
      .ld_vld      (ld_vld),
      .out_ready   (bus.out_ready),
      .data_q      (out_data),
      .vld_q       (out_vld),
      .out_valid_q (bus.out_valid),
      .ovf_q       (bus.ovf)
`ifdef PHY_RX_GRP_CNT_EN
      , .grp_cnt_q (bus.grp_cnt)
`endif
   );
   assign bus.Out0       = out_data[0];
   assign bus.Out1       = out_data[1];
   assign bus.Out2       = out_data[2];
   assign bus.Out3       = out_data[3];
   assign bus.valid_out0 = out_vld[0];
   assign bus.valid_out1 = out_vld[1];
   assign bus.valid_out2 = out_vld[2];
   assign bus.valid_out3 = out_vld[3];
endmodule

// File: tb/tb_phy_rx_lane_demux.sv
// tb_phy_rx_lane_demux: directed self-checking bench for phy_rx_lane_demux
module tb_phy_rx_lane_demux;
   logic clk = 1'b0;
   logic reset_L = 1'b0;
   int   errors = 0;
   int   checks = 0;
   phy_rx_lane_demux_if #(.DATA_W(8)) bus ();
   phy_rx_lane_demux #(.DATA_W(8), .LANES(4), .FLUSH_CYC(3)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] outs();
      return {bus.Out0, bus.Out1, bus.Out2, bus.Out3};
   endfunction
   function automatic logic [3:0] vlds();
      return {bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3};
   endfunction
   task automatic step(input logic v, input logic [7:0] d);
      bus.valid_in = v;
      bus.data_in  = d;
      @(posedge clk);
      #1;
   endtask
   task automatic send4(input logic [31:0] g);
      for (int i = 3; i >= 0; i--) step(1'b1, g[i*8 +: 8]);
   endtask
   task automatic test_reset();
      bus.valid_in = 1'b0; bus.data_in = 8'h00; bus.out_ready = 1'b0;
      reset_L = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (outs() !== 32'h0) begin errors++; $display("FAIL reset_outs: got %h want %h", outs(), 32'h0); end
      checks++; if ({bus.out_valid, bus.ovf, vlds()} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want %b", {bus.out_valid, bus.ovf, vlds()}, 6'b0); end
      reset_L = 1'b1;
      step(1'b0, 8'h00);
   endtask
   task automatic test_full_group();
      bus.out_ready = 1'b1;
      step(1'b1, 8'hFF); step(1'b1, 8'hEE); step(1'b1, 8'hDD);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", bus.out_valid); end
      step(1'b1, 8'hCC);
      checks++; if (outs() !== 32'hFFEEDDCC) begin errors++; $display("FAIL full_data: got %h want FFEEDDCC", outs()); end
      checks++; if ({bus.out_valid, vlds(), bus.ovf} !== 6'b111110) begin errors++; $display("FAIL full_flags: got %b want 111110", {bus.out_valid, vlds(), bus.ovf}); end
      step(1'b0, 8'h00);
      checks++; if ({bus.out_valid, vlds()} !== 5'b0) begin errors++; $display("FAIL accept_clear: got %b want 00000", {bus.out_valid, vlds()}); end
      checks++; if (outs() !== 32'hFFEEDDCC) begin errors++; $display("FAIL accept_hold: got %h want FFEEDDCC", outs()); end
   endtask
   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      send4(32'hFFEEDDCC);
      checks++; if (outs() !== 32'hFFEEDDCC || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_g1: got %h/%b want FFEEDDCC/1", outs(), bus.out_valid); end
      step(1'b1, 8'hBB); step(1'b1, 8'hAA); step(1'b1, 8'h99);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_mid: got %b want 0", bus.out_valid); end
      step(1'b1, 8'h88);
      checks++; if (outs() !== 32'hBBAA9988 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_g2: got %h/%b want BBAA9988/1", outs(), bus.out_valid); end
      step(1'b0, 8'h00);
   endtask
   task automatic test_partial_flush();
      bus.out_ready = 1'b1;
      step(1'b1, 8'h55); step(1'b1, 8'h55);
      step(1'b0, 8'h00); step(1'b0, 8'h00);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_early: got %b want 0", bus.out_valid); end
      step(1'b0, 8'h00);
      checks++; if (outs() !== 32'h55550000) begin errors++; $display("FAIL flush_data: got %h want 55550000", outs()); end
      checks++; if ({bus.out_valid, vlds()} !== 5'b11100) begin errors++; $display("FAIL flush_vld: got %b want 11100", {bus.out_valid, vlds()}); end
      step(1'b0, 8'h00);
   endtask
   task automatic test_no_flush();
      bus.out_ready = 1'b1;
      step(1'b1, 8'h11); step(1'b1, 8'h22);
      step(1'b0, 8'h00); step(1'b0, 8'h00);
      step(1'b1, 8'h77);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL noflush_early: got %b want 0", bus.out_valid); end
      step(1'b1, 8'h88);
      checks++; if (outs() !== 32'h11227788 || vlds() !== 4'hF) begin errors++; $display("FAIL noflush_data: got %h/%b want 11227788/1111", outs(), vlds()); end
      step(1'b0, 8'h00);
   endtask
   task automatic test_overflow();
      bus.out_ready = 1'b0;
      send4(32'hA1A2A3A4);
      checks++; if (outs() !== 32'hA1A2A3A4 || bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_first: got %h/%b want A1A2A3A4/0", outs(), bus.ovf); end
      send4(32'hB1B2B3B4);
      checks++; if (outs() !== 32'hA1A2A3A4 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %h/%b want A1A2A3A4/1", outs(), bus.out_valid); end
      checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
      bus.out_ready = 1'b1;
      step(1'b0, 8'h00);
      checks++; if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b/%b want 0/1", bus.out_valid, bus.ovf); end
   endtask
   task automatic test_accept_load();
      bus.out_ready = 1'b0;
      send4(32'h01020304);
      step(1'b1, 8'h05); step(1'b1, 8'h06); step(1'b1, 8'h07);
      checks++; if (outs() !== 32'h01020304) begin errors++; $display("FAIL accload_hold: got %h want 01020304", outs()); end
      bus.out_ready = 1'b1;
      step(1'b1, 8'h08);
      checks++; if (outs() !== 32'h05060708 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL accload_new: got %h/%b want 05060708/1", outs(), bus.out_valid); end
      step(1'b0, 8'h00);
   endtask
   task automatic test_reset_mid_group();
      bus.out_ready = 1'b1;
      step(1'b1, 8'h31); step(1'b1, 8'h32);
      bus.valid_in = 1'b0;
      reset_L = 1'b0;
      #2;
      checks++; if ({bus.out_valid, bus.ovf} !== 2'b00) begin errors++; $display("FAIL rst_async: got %b want 00", {bus.out_valid, bus.ovf}); end
      reset_L = 1'b1;
      repeat (4) step(1'b0, 8'h00);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_noflush: got %b want 0", bus.out_valid); end
      send4(32'h41424344);
      checks++; if (outs() !== 32'h41424344 || {bus.out_valid, bus.ovf} !== 2'b10) begin errors++; $display("FAIL rst_group: got %h/%b want 41424344/10", outs(), {bus.out_valid, bus.ovf}); end
`ifdef PHY_RX_GRP_CNT_EN
      checks++; if (bus.grp_cnt !== 16'd1) begin errors++; $display("FAIL grp_cnt: got %0d want 1", bus.grp_cnt); end
`endif
      step(1'b0, 8'h00);
   endtask
   initial begin
      test_reset();
      test_full_group();
      test_back_to_back();
      test_partial_flush();
      test_no_flush();
      test_overflow();
      test_accept_load();
      test_reset_mid_group();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
